// File: rtl/ifetch_buffer.sv
// Instruction-fetch buffer: issues single-beat imem requests for the current PC,
// tracks one outstanding fetch and queues {pc, instr} pairs for decode.
module ifetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            br_ctrl,
  output logic            pc_stall_o,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            id_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = PW + 2;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic [RW-1:0]   reserved;
  logic            accept;
  logic            push;
  logic            pop;
  logic            has_data;

  // Slots already committed: queued entries plus a kept fetch still in flight.
  assign reserved   = RW'(count_q) + ((state_q == WAIT) ? RW'(1) : RW'(0));
  assign accept     = imem_req & imem_gnt;
  assign pc_stall_o = ~accept & ~br_ctrl;
  assign imem_addr  = pc_i;

  assign has_data   = rst & (count_q != '0);
  assign id_valid   = has_data & ~br_ctrl;
  assign pop        = id_valid & id_ready;
  assign id_pc      = has_data ? pc_mem_q[rptr_q]    : '0;
  assign id_instr   = has_data ? instr_mem_q[rptr_q] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (br_ctrl) begin
          state_d = imem_rvalid ? IDLE : DISCARD;
        end else if (imem_rvalid) begin
          state_d = accept ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        if (imem_rvalid) state_d = accept ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new request may go out in the same cycle the previous response lands.
  always_comb begin
    imem_req = 1'b0;
    push     = 1'b0;
    if (rst && !br_ctrl && (reserved < RW'(DEPTH))) begin
      imem_req = (state_q == IDLE) || imem_rvalid;
    end
    push = imem_rvalid && (state_q == WAIT) && !br_ctrl;
  end

  always_comb begin
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (br_ctrl) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      req_pc_q <= '0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      if (accept) req_pc_q <= pc_i;
    end
  end

  // Storage is not reset; the head outputs are gated by count instead.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]    <= req_pc_q;
      instr_mem_q[wptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer with a PC-register model, a one-outstanding
// memory responder and a {pc, instr} scoreboard filled at grant time.
module tb_ifetch_buffer;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_ctrl = 1'b0;
  logic [31:0] br_addr = 32'h0;
  logic        imem_gnt = 1'b0;
  logic        id_ready = 1'b0;
  logic [31:0] pc_q = 32'h0;
  logic        pc_stall_o, imem_req, imem_rvalid, id_valid;
  logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;

  int          lat = 1;
  logic        bad_en = 1'b0;
  logic        resp_pend = 1'b0;
  logic        resp_bad = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = 32'h0;

  ent_t        sbq[$];
  int          errors = 0;
  int          checks = 0;

  ifetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_q), .br_ctrl(br_ctrl), .pc_stall_o(pc_stall_o),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst)             pc_q <= 32'h0;
    else if (br_ctrl)     pc_q <= br_addr;
    else if (!pc_stall_o) pc_q <= pc_q + 32'd4;
  end

  // Memory: answers each accepted request lat cycles later (lat>=1).
  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      resp_pend <= 1'b1;
      resp_cnt  <= lat;
      resp_addr <= imem_addr;
      resp_bad  <= bad_en;
    end else if (resp_pend && resp_cnt == 1) begin
      resp_pend <= 1'b0;
    end else if (resp_pend) begin
      resp_cnt <= resp_cnt - 1;
    end
  end

  assign imem_rvalid = resp_pend && (resp_cnt == 1);
  assign imem_rdata  = !imem_rvalid ? 32'h0 : (resp_bad ? 32'hDEADBEEF : (resp_addr ^ KEY));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic sample();
    ent_t e;
    @(negedge clk);
    if (!rst || br_ctrl) begin
      sbq.delete();
    end else begin
      if (id_valid && id_ready) begin
        if (sbq.size() == 0) begin
          chkb("sb_unexpected_pop", id_valid, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk("sb_pc", id_pc, e.pc);
          chk("sb_instr", id_instr, e.instr);
        end
      end
      if (imem_req && imem_gnt) begin
        e.pc    = imem_addr;
        e.instr = imem_addr ^ KEY;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    sync();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic drained(input string tag);
    sample();
    chkb({tag, "_idle"}, id_valid, 1'b0);
    chk({tag, "_sb_empty"}, sbq.size(), 32'd0);
    sync();
  endtask

  task automatic do_reset();
    rst = 1'b0; br_ctrl = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
    run(2);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sync();
    sample();
    chkb("rst_id_valid", id_valid, 1'b0);
    chkb("rst_imem_req", imem_req, 1'b0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    sync();
    cyc();
    rst = 1'b1;

    // Streaming with one-cycle memory latency
    imem_gnt = 1'b1; id_ready = 1'b1; lat = 1;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i < 4) begin
        chkb("t1_req", imem_req, 1'b1);
        chk("t1_addr", imem_addr, 32'(4 * i));
      end
      if (i >= 2) begin
        chkb("t1_valid", id_valid, 1'b1);
        chk("t1_id_pc", id_pc, 32'(4 * (i - 2)));
      end
      sync();
    end
    imem_gnt = 1'b0;
    run(4);
    drained("t1");

    // Backpressure fills exactly DEPTH entries
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i >= 4) begin
        chkb("t2_req_full", imem_req, 1'b0);
        chkb("t2_stall_full", pc_stall_o, 1'b1);
      end
      sync();
    end
    sample();
    chk("t2_entries", sbq.size(), 32'd4);
    chkb("t2_valid", id_valid, 1'b1);
    chk("t2_head_pc", id_pc, 32'h0);
    sync();
    id_ready = 1'b1;
    sample();
    chkb("t2_req_still_full", imem_req, 1'b0);
    sync();
    sample();
    chkb("t2_req_resume", imem_req, 1'b1);
    chk("t2_addr_resume", imem_addr, 32'h10);
    sync();
    imem_gnt = 1'b0;
    run(8);
    drained("t2");

    // Grant stall holds the request and address
    br_ctrl = 1'b1; br_addr = 32'h20;
    cyc();
    br_ctrl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chkb("t3_req", imem_req, 1'b1);
      chk("t3_addr", imem_addr, 32'h20);
      chkb("t3_stall", pc_stall_o, 1'b1);
      sync();
    end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    cyc();
    sample();
    chkb("t3_valid", id_valid, 1'b1);
    chk("t3_pc", id_pc, 32'h20);
    sync();
    sample();
    chkb("t3_single", id_valid, 1'b0);
    sync();

    // Redirect while a slow fetch is in flight
    br_ctrl = 1'b1; br_addr = 32'h10;
    cyc();
    br_ctrl = 1'b0; imem_gnt = 1'b1; lat = 3; bad_en = 1'b1;
    sample();
    chkb("t4_req", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 32'h10);
    sync();
    bad_en = 1'b0; imem_gnt = 1'b0; br_ctrl = 1'b1; br_addr = 32'h100;
    sample();
    chkb("t4_req_br", imem_req, 1'b0);
    chkb("t4_stall_br", pc_stall_o, 1'b0);
    chkb("t4_valid_br", id_valid, 1'b0);
    sync();
    br_ctrl = 1'b0; imem_gnt = 1'b1; lat = 1;
    sample();
    chkb("t4_req_discard", imem_req, 1'b0);
    chkb("t4_valid_discard", id_valid, 1'b0);
    sync();
    sample();
    chkb("t4_req_b2b", imem_req, 1'b1);
    chk("t4_addr_b2b", imem_addr, 32'h100);
    chkb("t4_valid_drop", id_valid, 1'b0);
    sync();
    sample();
    chkb("t4_valid_wait", id_valid, 1'b0);
    sync();
    sample();
    chkb("t4_valid_new", id_valid, 1'b1);
    chk("t4_pc_new", id_pc, 32'h100);
    chk("t4_instr_new", id_instr, 32'h100 ^ KEY);
    sync();
    imem_gnt = 1'b0;
    run(6);
    drained("t4");

    // Redirect in the same cycle as the response
    id_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
    run(2);
    imem_gnt = 1'b0; br_ctrl = 1'b1; br_addr = 32'h200;
    sample();
    chkb("t5_rvalid", imem_rvalid, 1'b1);
    chkb("t5_valid_br", id_valid, 1'b0);
    chkb("t5_req_br", imem_req, 1'b0);
    sync();
    br_ctrl = 1'b0;
    sample();
    chkb("t5_empty", id_valid, 1'b0);
    chkb("t5_idle_req", imem_req, 1'b1);
    chk("t5_addr", imem_addr, 32'h200);
    sync();
    imem_gnt = 1'b1; id_ready = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    cyc();
    sample();
    chkb("t5_valid_new", id_valid, 1'b1);
    chk("t5_pc_new", id_pc, 32'h200);
    sync();
    run(3);
    drained("t5");

    // Reset with entries queued and a fetch outstanding
    id_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
    run(2);
    lat = 3;
    cyc();
    rst = 1'b0; imem_gnt = 1'b0;
    sample();
    chkb("t6_valid_rst", id_valid, 1'b0);
    chkb("t6_req_rst", imem_req, 1'b0);
    chk("t6_pc_rst", id_pc, 32'h0);
    chk("t6_instr_rst", id_instr, 32'h0);
    sync();
    rst = 1'b1;
    sample();
    chkb("t6_valid_after", id_valid, 1'b0);
    sync();
    sample();
    chkb("t6_stray_rvalid", imem_rvalid, 1'b1);
    chkb("t6_req_idle", imem_req, 1'b1);
    chk("t6_addr_zero", imem_addr, 32'h0);
    sync();
    sample();
    chkb("t6_stray_ignored", id_valid, 1'b0);
    sync();
    imem_gnt = 1'b1; id_ready = 1'b1; lat = 1;
    cyc();
    imem_gnt = 1'b0;
    cyc();
    sample();
    chkb("t6_valid_first", id_valid, 1'b1);
    chk("t6_pc_first", id_pc, 32'h0);
    sync();
    run(3);
    drained("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
